// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
// fetch_entry_t is the default-width FIFO entry layout; the top re-declares it at its own widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD,
        HALTED
    } fetch_state_t;

    localparam int unsigned PC_INC     = 2;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_INST_W = 16;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is read straight from storage.
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush takes priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a DEPTH-entry FIFO to decode.
// Optional macro PREFETCH_BYPASS_EN: zero-latency response-to-decode when the FIFO is empty.
module inst_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INST_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [CNT_W-1:0]  count;
    entry_t            rsp_entry;
    entry_t            head_entry;
    logic              full;
    logic              accept;
    logic              rsp_push;
    logic              fifo_push;
    logic              fifo_pop;

    // The free slot check reserves space for the single outstanding response.
    assign full          = (count == CNT_W'(DEPTH));
    assign mem_req_valid = rst_n && (state == FETCH) && !halt && !full;
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;
    assign halted        = (state == HALTED);
    assign rsp_entry     = '{pc: fetch_pc - ADDR_W'(PC_INC), inst: mem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = fetch_pc;
        rsp_push = 1'b0;
        case (state)
            FETCH: begin
                if (accept) begin
                    pc_nx    = fetch_pc + ADDR_W'(PC_INC);
                    state_nx = WAIT;
                end else if (halt) begin
                    state_nx = HALTED;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_push = 1'b1;
                    state_nx = halt ? HALTED : FETCH;
                end
            end
            DISCARD: begin
                if (mem_rsp_valid) begin
                    state_nx = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
        endcase
        // Redirect overrides: any request still in flight after this edge must be discarded.
        if (redirect) begin
            rsp_push = 1'b0;
            pc_nx    = {redirect_pc[ADDR_W-1:1], 1'b0};
            case (state)
                FETCH:         state_nx = accept ? DISCARD : FETCH;
                WAIT, DISCARD: state_nx = mem_rsp_valid ? FETCH : DISCARD;
                default:       state_nx = FETCH;
            endcase
        end
    end

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass     = rsp_push && (count == '0);
    assign inst_valid = (count != '0) || bypass;
    assign inst_pc    = bypass ? rsp_entry.pc   : head_entry.pc;
    assign inst_data  = bypass ? rsp_entry.inst : head_entry.inst;
    assign fifo_push  = rsp_push && !(bypass && inst_ready);
`else
    assign inst_valid = (count != '0);
    assign inst_pc    = head_entry.pc;
    assign inst_data  = head_entry.inst;
    assign fifo_push  = rsp_push;
`endif

    assign fifo_pop = (count != '0) && inst_ready;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .count     (count),
        .head      (head_entry)
    );

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_inst_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        mem_req_valid;
    logic [15:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [15:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [15:0] fetch_pc;
    logic        halted;

    always #5 clk = ~clk;

    inst_prefetch_unit #(
        .ADDR_W   (16),
        .INST_W   (16),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .fetch_pc      (fetch_pc),
        .halted        (halted)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    // Reference model: the decode-visible instruction stream and the expected fetch address.
    logic [15:0] q[$];
    logic [15:0] exp_pc = RESET_PC;
    bit          halted_m = 0;
    bit          live = 0;
    // Memory model: one outstanding request with configurable latency.
    bit          mem_pending = 0;
    int          lat_left = 0;
    logic [15:0] mem_addr = '0;
    int          lat_cfg = 3;
    bit          rdy_rand = 0;
    // Observations of the DUT used by directed scenarios.
    logic [15:0] acc_log[$];
    int          acc_cyc[$];
    int          first_valid_cyc = -1;

    function automatic logic [15:0] inst_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic tick();
        bit          out_now;
        bit          rsp;
        bit          acc;
        bit          pop;
        bit          exp_rv;
        logic [15:0] rsp_pc;
        @(negedge clk);
        out_now = mem_pending;
        rsp_pc  = mem_addr;
        rsp     = 0;
        if (rst_n) begin
            rsp = mem_pending && (lat_left == 0);
            if (mem_pending) begin
                if (lat_left == 0) mem_pending = 0;
                else lat_left--;
            end
            mem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
            mem_req_ready = 1'b0;
        end
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? inst_of(rsp_pc) : 16'($urandom);
        #1;
        if (!rst_n) begin
            q.delete();
            exp_pc      = RESET_PC;
            halted_m    = 0;
            live        = 0;
            mem_pending = 0;
        end else begin
            exp_rv = !halt && !halted_m && !out_now && (q.size() < DEPTH);
            n_checks++;
            if (mem_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, exp_rv);
            end
            n_checks++;
            if (fetch_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL fetch_pc cyc=%0d got=%h exp=%h", cyc, fetch_pc, exp_pc);
            end
            n_checks++;
            if (halted !== halted_m) begin
                n_fail++;
                $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, halted_m);
            end
            n_checks++;
            if (inst_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, q.size() != 0);
            end
            if (exp_rv) begin
                n_checks++;
                if (mem_req_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, exp_pc);
                end
            end
            if (q.size() != 0) begin
                n_checks++;
                if (inst_pc !== q[0] || inst_data !== inst_of(q[0])) begin
                    n_fail++;
                    $display("FAIL head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                             cyc, inst_pc, inst_data, q[0], inst_of(q[0]));
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                acc_log.push_back(mem_req_addr);
                acc_cyc.push_back(cyc);
            end
            if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            acc = exp_rv && mem_req_ready;
            pop = (q.size() != 0) && inst_ready;
            if (pop && !redirect) void'(q.pop_front());
            if (rsp && live && !redirect) q.push_back(rsp_pc);
            if (acc) begin
                mem_pending = 1;
                mem_addr    = exp_pc;
                lat_left    = ((lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg) - 1;
                live        = !redirect;
                exp_pc      = exp_pc + 16'd2;
            end
            if (redirect) begin
                q.delete();
                live   = 0;
                exp_pc = redirect_pc & 16'hFFFE;
            end
            halted_m = halted_m ? !redirect : (halt && !redirect && !mem_pending);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        acc_log.delete();
        acc_cyc.delete();
        first_valid_cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", halted); end
        n_checks++;
        if (fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL rst_fetch_pc got=%h exp=%h", fetch_pc, RESET_PC); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_first_req got valid=%b addr=%h exp valid=1 addr=%h", mem_req_valid, mem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_latency();
        lat_cfg = 3; rdy_rand = 0; inst_ready = 1'b1;
        apply_reset();
        repeat (14) tick();
        n_checks++;
        if (acc_log.size() < 3) begin
            n_fail++;
            $display("FAIL lat_req_count got=%0d exp>=3", acc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_log[i] !== 16'(2 * i)) begin
                    n_fail++;
                    $display("FAIL lat_req_addr%0d got=%h exp=%h", i, acc_log[i], 16'(2 * i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL lat_req_gap%0d got=%0d exp=4", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
            n_checks++;
            if (first_valid_cyc - acc_cyc[0] != 4) begin
                n_fail++;
                $display("FAIL lat_first_valid got=%0d exp=4", first_valid_cyc - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_full();
        lat_cfg = 2; inst_ready = 1'b0;
        apply_reset();
        repeat (30) tick();
        n_checks++;
        if (acc_log.size() != DEPTH) begin n_fail++; $display("FAIL full_req_count got=%0d exp=%0d", acc_log.size(), DEPTH); end
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid got=%b exp=0", mem_req_valid); end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL full_head got valid=%b pc=%h exp valid=1 pc=0000", inst_valid, inst_pc);
        end
        acc_log.delete();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (acc_log.size() != 1) begin
            n_fail++;
            $display("FAIL full_refill_count got=%0d exp=1", acc_log.size());
        end else begin
            n_checks++;
            if (acc_log[0] !== 16'h0008) begin n_fail++; $display("FAIL full_refill_addr got=%h exp=0008", acc_log[0]); end
        end
    endtask

    task automatic test_redirect_wait();
        lat_cfg = 3; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 8 && !mem_pending; i++) tick();
        n_checks++;
        if (!mem_pending || lat_left == 0) begin n_fail++; $display("FAIL rw_wait_timeout got pending=%b exp=1", mem_pending); end
        redirect = 1'b1; redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (fetch_pc !== 16'h0040) begin n_fail++; $display("FAIL rw_fetch_pc got=%h exp=0040", fetch_pc); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush got=%b exp=0", inst_valid); end
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_discard_req got=%b exp=0", mem_req_valid); end
        acc_log.delete();
        for (int i = 0; i < 10 && acc_log.size() == 0; i++) tick();
        n_checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 16'h0040) begin
            n_fail++;
            $display("FAIL rw_next_req got count=%0d exp count=1 addr=0040", acc_log.size());
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 10 && !inst_valid; i++) tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0040 || inst_data !== inst_of(16'h0040)) begin
            n_fail++;
            $display("FAIL rw_head got valid=%b pc=%h data=%h exp pc=0040 data=%h",
                     inst_valid, inst_pc, inst_data, inst_of(16'h0040));
        end
    endtask

    task automatic test_redirect_rsp();
        lat_cfg = 3; inst_ready = 1'b1;
        for (int i = 0; i < 20 && !(mem_pending && lat_left == 0); i++) tick();
        n_checks++;
        if (!(mem_pending && lat_left == 0)) begin n_fail++; $display("FAIL rr_timeout got pending=%b exp=1", mem_pending); end
        redirect = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0080) begin
            n_fail++;
            $display("FAIL rr_req got valid=%b addr=%h exp valid=1 addr=0080", mem_req_valid, mem_req_addr);
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_not_enqueued got=%b exp=0", inst_valid); end
    endtask

    task automatic test_halt();
        lat_cfg = 3; inst_ready = 1'b0;
        apply_reset();
        tick();
        halt = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got=%b exp=1", halted); end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL halt_enqueued got valid=%b pc=%h exp valid=1 pc=0000", inst_valid, inst_pc);
        end
        n_checks++;
        if (acc_log.size() != 1) begin n_fail++; $display("FAIL halt_req_count got=%0d exp=1", acc_log.size()); end
        halt = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (halted !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_sticky got halted=%b req=%b exp halted=1 req=0", halted, mem_req_valid);
        end
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL halt_resume got halted=%b req=%b addr=%h exp halted=0 req=1 addr=0100",
                     halted, mem_req_valid, mem_req_addr);
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_flush got=%b exp=0", inst_valid); end
    endtask

    task automatic test_wrap_and_reset();
        lat_cfg = 1; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 12 && acc_log.size() < 2; i++) tick();
        n_checks++;
        if (acc_log.size() < 2) begin
            n_fail++;
            $display("FAIL wrap_timeout got=%0d exp>=2", acc_log.size());
        end else begin
            n_checks++;
            if (acc_log[0] !== 16'hFFFE || acc_log[1] !== 16'h0000) begin
                n_fail++;
                $display("FAIL wrap_addr got=%h,%h exp=fffe,0000", acc_log[0], acc_log[1]);
            end
        end
        lat_cfg = 3;
        for (int i = 0; i < 12 && !(mem_pending && lat_left != 0); i++) tick();
        n_checks++;
        if (!(mem_pending && lat_left != 0)) begin n_fail++; $display("FAIL mrst_timeout got pending=%b exp=1", mem_pending); end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || fetch_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL mrst_outputs got req=%b iv=%b halted=%b pc=%h exp 0 0 0 %h",
                     mem_req_valid, inst_valid, halted, fetch_pc, RESET_PC);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL mrst_first_req got valid=%b addr=%h exp valid=1 addr=%h", mem_req_valid, mem_req_addr, RESET_PC);
        end
        repeat (10) tick();
    endtask

    task automatic test_random();
        apply_reset();
        rdy_rand = 1; lat_cfg = 0;
        repeat (3000) begin
            inst_ready  = ($urandom_range(0, 9) < 7);
            halt        = ($urandom_range(0, 99) < 3);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = 16'($urandom);
            tick();
        end
        redirect = 1'b0; halt = 1'b0; rdy_rand = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_redirect_wait();
        test_redirect_rsp();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
